fft_frame_feeder: RTL

//   Input-side frame buffer placed directly upstream of fft_sc. Accepts a bursty

---
 rtl/fft_frame_feeder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//   Ping-pong frame buffer in front of fft_sc. Absorbs a bursty sample stream
//   (valid/ready) and replays each complete frame as FFT_SIZE back-to-back
//   valid cycles, then forces FRAME_GAP idle cycles so fft_sc restarts its
//   frame counter cleanly.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   s_re/s_im        input sample (16b each)
//   s_valid/s_ready  input handshake; transfer when both high
//   m_re/m_im        burst sample, held while m_valid=0
//   m_valid          burst valid, no backpressure
//   m_last           high with the FFT_SIZE-th sample of each burst
//   frames_full      complete frames currently buffered, 0..2
module fft_frame_feeder #(
    parameter int FFT_SIZE  = 32,
    parameter int FRAME_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_re,
    input  logic [15:0] s_im,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_re,
    output logic [15:0] m_im,
    output logic        m_valid,
    output logic        m_last,
    output logic [1:0]  frames_full
);
    localparam int AW = $clog2(FFT_SIZE);
    localparam int GW = $clog2(FRAME_GAP + 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t         state, state_nxt;
    logic [31:0]    mem [0:2*FFT_SIZE-1];
    logic           wr_bank, rd_bank;
    logic [AW-1:0]  wr_idx, rd_idx;
    logic [GW-1:0]  gap_cnt;
    logic [1:0]     ff_nxt;
    logic           wr_fire, wr_done, rd_done;
    logic           rd_en, rd_last;

    assign wr_fire = s_valid && s_ready;
    assign wr_done = wr_fire && (wr_idx == AW'(FFT_SIZE - 1));
    assign rd_done = m_valid && m_last;

    // A frame completing while another retires leaves the count unchanged.
    always_comb begin
        ff_nxt = frames_full;
        if (wr_done && !rd_done)
            ff_nxt = frames_full + 2'd1;
        else if (!wr_done && rd_done)
            ff_nxt = frames_full - 2'd1;
    end

    // ---------------- read FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- read FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frames_full != 2'd0)               state_nxt = BURST;
            BURST:   if (rd_idx == AW'(FFT_SIZE - 1))       state_nxt = GAP;
            GAP:     if (gap_cnt == GW'(FRAME_GAP - 1))     state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    // ---------------- read FSM: outputs ----------------
    // IDLE issues the index-0 read on the same cycle it decides to start, so
    // the burst then runs without a bubble.
    always_comb begin
        rd_en   = 1'b0;
        rd_last = 1'b0;
        case (state)
            IDLE:  rd_en = (frames_full != 2'd0);
            BURST: begin
                rd_en   = 1'b1;
                rd_last = (rd_idx == AW'(FFT_SIZE - 1));
            end
            default: ;
        endcase
    end

    // Sample storage; no reset needed, pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire)
            mem[{wr_bank, wr_idx}] <= {s_re, s_im};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            wr_idx      <= '0;
            rd_bank     <= 1'b0;
            rd_idx      <= '0;
            gap_cnt     <= '0;
            frames_full <= 2'd0;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_re        <= '0;
            m_im        <= '0;
        end else begin
            if (wr_fire) begin
                wr_idx <= wr_idx + 1'b1;     // wraps at FFT_SIZE (power of two)
                if (wr_done) wr_bank <= ~wr_bank;
            end
            frames_full <= ff_nxt;
            // Ready follows the next count so a second completed frame blocks
            // the very next transfer; the writer can never enter the bank
            // still being replayed.
            s_ready     <= (ff_nxt != 2'd2);

            m_valid <= rd_en;
            m_last  <= rd_last;
            if (rd_en) begin
                m_re   <= mem[{rd_bank, rd_idx}][31:16];
                m_im   <= mem[{rd_bank, rd_idx}][15:0];
                rd_idx <= rd_idx + 1'b1;     // returns to 0 after the last read
            end
            if (rd_done) rd_bank <= ~rd_bank;

            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

endmodule
